pipe_stage_chain: RTL and testbench

Parametrised chain of pipeline registers for the pipelined RISC-V datapath. It generalises the single-bit reset flop to WIDTH-bit, DEPTH-stage storage, with a valid bit per stage. It supports per-stage stall with upstream propagation, automatic bubble insertion, per-stage flush, and a registered count of occupied stages. Typical uses are inter-stage buses (IF/ID … MEM/WB) and delay lines for hazard/forwarding bookkeeping.

---
 rtl/pipe_stage_chain_if.sv | 29 ++
 rtl/pipe_stage_chain.sv | 105 ++++++++++
 tb/tb_pipe_stage_chain.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Bundle of the pipe_stage_chain datapath/handshake signals.
//   master : producer/controller side (drives in_data, in_valid, stall, flush;
//            observes in_ready and all stage state)
//   slave  : the chain itself (the reverse directions)
interface pipe_stage_chain_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    logic [WIDTH-1:0]             in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [DEPTH-1:0]             stall;
    logic [DEPTH-1:0]             flush;
    logic [DEPTH-1:0]             stage_valid;
    logic [DEPTH*WIDTH-1:0]       stage_data;
    logic [WIDTH-1:0]             out_data;
    logic                         out_valid;
    logic [$clog2(DEPTH+1)-1:0]   valid_count;

    modport master (
        output in_data, in_valid, stall, flush,
        input  in_ready, stage_valid, stage_data, out_data, out_valid, valid_count
    );

    modport slave (
        input  in_data, in_valid, stall, flush,
        output in_ready, stage_valid, stage_data, out_data, out_valid, valid_count
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage chain of WIDTH-bit pipeline registers, each with a valid bit.
// Supports per-stage stall (propagating upstream), bubble insertion below a
// stalled region, per-stage flush and a registered occupancy count.
// Ports:
//   clk  - clock, all state updates on rising edge
//   rst  - synchronous active-low reset
//   bus  - pipe_stage_chain_if.slave: in_data/in_valid/in_ready (stage 0
//          input handshake), stall/flush (per stage), stage_valid/stage_data
//          (registered stage state), out_data/out_valid (last stage),
//          valid_count (registered popcount of stage_valid)
module pipe_stage_chain #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    pipe_stage_chain_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;

    // hold[i] = OR of stall[j] for j >= i; done with a shift rather than a
    // chained hold[i+1] reference to keep the net free of self-dependence.
    always_comb begin
        hold = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hold[i] = |(bus.stall >> i);
        end
    end

    // Per-stage priority: flush > hold > advance (reset handled in the flop).
    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end

        if (bus.flush[0]) begin
            valid_d[0] = 1'b0;
            data_d[0]  = RST_VAL;
        end else if (!hold[0]) begin
            valid_d[0] = bus.in_valid;
            data_d[0]  = bus.in_valid ? bus.in_data : RST_VAL;
        end

        for (int unsigned i = 1; i < DEPTH; i++) begin
            if (bus.flush[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = RST_VAL;
            end else if (hold[i]) begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
            end else if (hold[i-1]) begin
                // Upstream neighbour is frozen: fill the gap with a bubble.
                valid_d[i] = 1'b0;
                data_d[i]  = RST_VAL;
            end else begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        bus.stage_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            bus.stage_data[i*WIDTH +: WIDTH] = data_q[i];
        end
    end

    assign bus.in_ready    = ~hold[0];
    assign bus.stage_valid = valid_q;
    assign bus.out_data    = data_q[DEPTH-1];
    assign bus.out_valid   = valid_q[DEPTH-1];
    assign bus.valid_count = count_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (WIDTH=8, DEPTH=3, RST_VAL=0).
module tb_pipe_stage_chain;
    localparam int unsigned W = 8;
    localparam int unsigned D = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_stage_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .RST_VAL(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the frozen region is every stage up to the highest stalled one;
    // the stage just below it receives a bubble, stages further down shift,
    // and flush overrides everything for its stage.
    bit       m_known;
    bit       m_v [D];
    bit [7:0] m_d [D];

    always @(posedge clk) begin
        int       top;
        bit       nv [D];
        bit [7:0] nd [D];
        top = -1;
        for (int s = 0; s < D; s++) if (bus.stall[s]) top = s;
        for (int s = 0; s < D; s++) begin
            if (!rst || bus.flush[s]) begin
                nv[s] = 0; nd[s] = 8'h00;
            end else if (s <= top) begin
                nv[s] = m_v[s]; nd[s] = m_d[s];
            end else if (s == top + 1 && s != 0) begin
                nv[s] = 0; nd[s] = 8'h00;
            end else if (s == 0) begin
                nv[s] = bus.in_valid; nd[s] = bus.in_valid ? bus.in_data : 8'h00;
            end else begin
                nv[s] = m_v[s-1]; nd[s] = m_d[s-1];
            end
        end
        if (!rst) m_known <= 1;
        for (int s = 0; s < D; s++) begin
            m_v[s] <= nv[s];
            m_d[s] <= nd[s];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [2:0]  ev;
        logic [23:0] ed;
        int          cnt;
        if (m_known) begin
            cnt = 0;
            for (int s = 0; s < D; s++) begin
                ev[s] = m_v[s];
                ed[s*8 +: 8] = m_d[s];
                cnt += int'(m_v[s]);
            end
            chk("model_stage_valid", 32'(bus.stage_valid), 32'(ev));
            chk("model_stage_data",  32'(bus.stage_data),  32'(ed));
            chk("model_out_data",    32'(bus.out_data),    32'(m_d[D-1]));
            chk("model_out_valid",   32'(bus.out_valid),   32'(m_v[D-1]));
            chk("model_valid_count", 32'(bus.valid_count), 32'(cnt));
            chk("model_in_ready",    32'(bus.in_ready),    32'(bus.stall == 3'b000));
        end
    end

    task automatic drive(input bit r, input bit iv, input logic [7:0] id,
                         input logic [2:0] st, input logic [2:0] fl);
        rst          = r;
        bus.in_valid = iv;
        bus.in_data  = id;
        bus.stall    = st;
        bus.flush    = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_st(input string name, input logic [2:0] v,
                             input logic [23:0] d, input logic [1:0] c);
        chk({name, "_valid"}, 32'(bus.stage_valid), 32'(v));
        chk({name, "_data"},  32'(bus.stage_data),  32'(d));
        chk({name, "_count"}, 32'(bus.valid_count), 32'(c));
    endtask

    typedef struct packed {
        bit         iv;
        logic [7:0] id;
        logic [2:0] st;
        logic [2:0] fl;
    } vec_t;

    vec_t tbl [8];

    initial begin
        checks  = 0;
        errors  = 0;
        m_known = 0;
        tbl[0] = '{1'b1, 8'hC1, 3'b000, 3'b000};
        tbl[1] = '{1'b1, 8'hC2, 3'b010, 3'b000};
        tbl[2] = '{1'b1, 8'hC3, 3'b000, 3'b001};
        tbl[3] = '{1'b1, 8'hC4, 3'b001, 3'b100};
        tbl[4] = '{1'b0, 8'hC5, 3'b110, 3'b010};
        tbl[5] = '{1'b1, 8'hC6, 3'b000, 3'b111};
        tbl[6] = '{1'b1, 8'hC7, 3'b100, 3'b001};
        tbl[7] = '{1'b1, 8'hC8, 3'b000, 3'b000};

        // Reset for two edges.
        drive(0, 1, 8'hAA, 3'b000, 3'b000);
        tick();
        tick();
        expect_st("reset", 3'b000, 24'h000000, 2'd0);

        // Streaming 0x11, 0x22, 0x33.
        drive(1, 1, 8'h11, 3'b000, 3'b000); tick();
        expect_st("stream1", 3'b001, 24'h000011, 2'd1);
        drive(1, 1, 8'h22, 3'b000, 3'b000); tick();
        drive(1, 1, 8'h33, 3'b000, 3'b000); tick();
        chk("stream_out_data",  32'(bus.out_data),  32'h11);
        chk("stream_out_valid", 32'(bus.out_valid), 32'h1);
        expect_st("stream3", 3'b111, 24'h112233, 2'd3);

        // Load-use bubble: stall[0] one cycle with 0x44 offered.
        drive(1, 1, 8'h44, 3'b001, 3'b000);
        chk("loaduse_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        expect_st("loaduse", 3'b101, 24'h220033, 2'd2);
        drive(1, 1, 8'h44, 3'b000, 3'b000); tick();
        expect_st("loaduse_accept", 3'b011, 24'h003344, 2'd2);

        // Stall on the last stage freezes everything.
        drive(1, 1, 8'h66, 3'b100, 3'b000);
        chk("stall2_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        expect_st("stall2_a", 3'b011, 24'h003344, 2'd2);
        tick();
        expect_st("stall2_b", 3'b011, 24'h003344, 2'd2);

        // Flush stage 1 while stall[2] holds the rest.
        drive(1, 1, 8'h66, 3'b100, 3'b010); tick();
        expect_st("flush1_stall2", 3'b001, 24'h000044, 2'd1);

        // Refill, then flush+stall on stage 2.
        drive(1, 1, 8'h77, 3'b000, 3'b000); tick();
        drive(1, 1, 8'h88, 3'b000, 3'b000); tick();
        expect_st("refill", 3'b111, 24'h447788, 2'd3);
        drive(1, 1, 8'h99, 3'b100, 3'b100); tick();
        expect_st("flush2_stall2", 3'b011, 24'h007788, 2'd2);

        // Bubble input with non-zero data.
        drive(1, 0, 8'hFF, 3'b000, 3'b000); tick();
        expect_st("bubble_in", 3'b110, 24'h778800, 2'd2);
        tick();
        tick();
        chk("bubble_out_valid", 32'(bus.out_valid), 32'h0);
        chk("bubble_out_data",  32'(bus.out_data),  32'h00);

        // Mid-stream reset.
        drive(1, 1, 8'hA1, 3'b000, 3'b000); tick();
        drive(1, 1, 8'hA2, 3'b000, 3'b000); tick();
        drive(1, 1, 8'hA3, 3'b000, 3'b000); tick();
        expect_st("prefill", 3'b111, 24'hA1A2A3, 2'd3);
        drive(0, 1, 8'hA4, 3'b000, 3'b000); tick();
        expect_st("midreset", 3'b000, 24'h000000, 2'd0);
        drive(1, 1, 8'h55, 3'b000, 3'b000); tick();
        drive(1, 0, 8'h00, 3'b000, 3'b000); tick();
        tick();
        chk("postreset_out_data",  32'(bus.out_data),  32'h55);
        chk("postreset_out_valid", 32'(bus.out_valid), 32'h1);

        // Mixed stall/flush table, checked by the model each cycle.
        foreach (tbl[k]) begin
            drive(1, tbl[k].iv, tbl[k].id, tbl[k].st, tbl[k].fl);
            tick();
        end
        drive(1, 0, 8'h00, 3'b000, 3'b000);
        tick();
        tick();
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
